dsp_add_arbiter: RTL and testbench
==================================

DSP_ADD_ARBITER -- requirements
Module: dsp_add_arbiter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning operand/result width in bits.
REQ-002 The block SHALL have parameter NREQ, default 4, meaning number of requesters (2..8).
REQ-003 The block SHALL have parameter LAT, default 2, meaning adder pipeline depth in cycles (>=1).
REQ-004 The block SHALL have parameter DEPTH, default 4, meaning result FIFO entries (>=1).
REQ-005 The block SHALL have port clock, input, 1, meaning the single clock; all state changes on the posedge.
REQ-006 The block SHALL have port reset, input, 1, meaning synchronous active-high reset.
REQ-007 The block SHALL have port req_valid, input, NREQ, meaning per-requester operand valid.
REQ-008 The block SHALL have port req_ready, output, NREQ, meaning per-requester grant/accept.
REQ-009 The block SHALL have port req_a, input, NREQ*WIDTH, meaning operand a, requester i at bits [i*WIDTH +: WIDTH].
REQ-010 The block SHALL have port req_b, input, NREQ*WIDTH, meaning operand b, same packing as req_a.
REQ-011 The block SHALL have port rsp_valid, output, 1, meaning result available at the FIFO head.
REQ-012 The block SHALL have port rsp_ready, input, 1, meaning consumer accepts the head result.
REQ-013 The block SHALL have port rsp_id, output, clog2(NREQ), meaning requester index of the head result.
REQ-014 The block SHALL have port rsp_y, output, WIDTH, meaning head result value.

Function
REQ-015 A transfer SHALL occur on requester i when req_valid[i] and req_ready[i] are both high at a posedge.
REQ-016 At most one req_ready bit SHALL be high per cycle; req_ready SHALL depend combinationally on req_valid, the RR pointer and credit, and SHALL never be high for a requester whose valid is low.
REQ-017 Arbitration SHALL be round-robin: grant the first valid requester at index ptr, ptr+1, ... wrapping mod NREQ.
REQ-018 On a transfer by requester g, ptr SHALL become (g+1) mod NREQ; with no transfer, ptr SHALL hold.
REQ-019 credit SHALL equal DEPTH - fifo_count - inflight; a grant SHALL be issued only when credit > 0.
REQ-020 Credit SHALL count a FIFO pop in the same cycle, so a grant is allowed when credit == 0 and rsp_valid && rsp_ready hold in that cycle.
REQ-021 The datapath SHALL compute y = (a + b) mod 2^WIDTH, with the carry discarded and no saturation; signed and unsigned interpretations are identical.
REQ-022 Operands and the id accepted at edge t SHALL be written to the FIFO at edge t+LAT, with rsp_valid high from cycle t+LAT onward.
REQ-023 The pipeline SHALL carry a per-stage valid bit and id, so that bubbles occupy no credit.
REQ-024 The FIFO SHALL preserve grant order, with rsp_id, rsp_y and rsp_valid stable while rsp_valid && !rsp_ready.
REQ-025 Pop and push in the same cycle SHALL leave fifo_count unchanged; pop on empty and push on full SHALL be impossible by construction, checked by assertions.
REQ-026 inflight SHALL be a counter that is incremented on grant and decremented on pipeline exit; a simultaneous increment and decrement SHALL leave it unchanged.
REQ-027 FIFO pointers SHALL wrap mod DEPTH, supporting non-power-of-two DEPTH.

Reset
REQ-028 While reset is high, req_ready SHALL be 0 and rsp_valid SHALL be 0.
REQ-029 Reset SHALL set ptr=0, fifo_count=0, inflight=0 and all pipeline valids to 0.
REQ-030 Reset mid-operation SHALL discard all in-flight and queued results, and no response SHALL emerge after reset deasserts.
REQ-031 The first grant SHALL be possible in the first cycle with reset low.

Verification
REQ-032 Single op: req 0 a=8'd0, b=-8'd2, rsp_ready=1 -> one rsp at t+2 with rsp_y=8'hFE (-2 signed), rsp_id=0.
REQ-033 Wrap: a=8'h7F,b=8'h01 -> rsp_y=8'h80; a=8'hFF,b=8'h01 -> rsp_y=8'h00.
REQ-034 Fairness: all 4 valid continuously, rsp_ready=1 -> grant order 0,1,2,3,0,1,... with one grant per cycle and no gaps.
REQ-035 Backpressure: all valid, rsp_ready=0 -> exactly 4 transfers then req_ready=0; raising rsp_ready -> results pop in grant order and grants resume in the pop cycle.
REQ-036 Reset mid-flight: reset asserted for 1 cycle with 2 ops in pipe and 2 in the FIFO -> rsp_valid=0 and ptr=0 afterward, and the next request served is from index 0 upward.
REQ-037 Sparse: only req 2 valid, then only req 1 -> grants go to 2 then 1, ptr=2 after the second grant, and every result matches a golden model a+b.

Source files
------------

// File: rtl/dsp_add_arbiter.sv
// Round-robin arbiter feeding a pipelined wrap-around adder with a credit-guarded result FIFO.
// Requesters are granted only when the FIFO is guaranteed to have room for the result.
module dsp_add_arbiter #(
   parameter int WIDTH = 8,
   parameter int NREQ  = 4,
   parameter int LAT   = 2,
   parameter int DEPTH = 4
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic [NREQ-1:0]            req_valid,
   output logic [NREQ-1:0]            req_ready,
   input  logic [NREQ*WIDTH-1:0]      req_a,
   input  logic [NREQ*WIDTH-1:0]      req_b,
   output logic                       rsp_valid,
   input  logic                       rsp_ready,
   output logic [$clog2(NREQ)-1:0]    rsp_id,
   output logic [WIDTH-1:0]           rsp_y
);

   localparam int IDW = $clog2(NREQ);
   localparam int CW  = $clog2(DEPTH + 1);
   localparam int PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [IDW-1:0]          ptr;
   logic [IDW-1:0]          gnt_idx;
   logic                    gnt_found;
   logic [IDW:0]            rr_sum;
   logic [IDW-1:0]          rr_idx;
   logic                    credit_ok;
   logic                    grant;
   logic                    pop;
   logic                    push;
   logic [CW-1:0]           fifo_count;
   logic [CW-1:0]           inflight;
   logic [CW:0]             occupancy;
   logic signed [WIDTH-1:0] a_sel;
   logic signed [WIDTH-1:0] b_sel;

   logic [LAT-1:0]          vld_p;
   logic [IDW-1:0]          id_p [LAT];
   logic signed [WIDTH-1:0] y_p  [LAT];

   logic [IDW-1:0]          mem_id [DEPTH];
   logic [WIDTH-1:0]        mem_y  [DEPTH];
   logic [PW-1:0]           wr_ptr;
   logic [PW-1:0]           rd_ptr;

   // Two's-complement add with the carry dropped: identical for signed and unsigned operands.
   function automatic logic signed [WIDTH-1:0] add_wrap(input logic signed [WIDTH-1:0] a,
                                                        input logic signed [WIDTH-1:0] b);
      return a + b;
   endfunction

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   // Scan requesters starting at ptr, wrapping mod NREQ.
   always_comb begin
      gnt_found = 1'b0;
      gnt_idx   = '0;
      rr_sum    = '0;
      rr_idx    = '0;
      for (int k = 0; k < NREQ; k++) begin
         rr_sum = {1'b0, ptr} + (IDW+1)'(k);
         if (rr_sum >= (IDW+1)'(NREQ)) rr_sum = rr_sum - (IDW+1)'(NREQ);
         rr_idx = rr_sum[IDW-1:0];
         if (!gnt_found && req_valid[rr_idx]) begin
            gnt_found = 1'b1;
            gnt_idx   = rr_idx;
         end
      end
   end

   // A pop this cycle frees a slot, so it counts toward credit immediately.
   assign rsp_valid = !reset && (fifo_count != '0);
   assign pop       = rsp_valid && rsp_ready;
   assign occupancy = {1'b0, fifo_count} + {1'b0, inflight};
   assign credit_ok = (occupancy < (CW+1)'(DEPTH)) || pop;
   assign grant     = !reset && gnt_found && credit_ok;
   assign req_ready = grant ? (NREQ'(1) << gnt_idx) : '0;
   assign push      = vld_p[LAT-1];

   assign a_sel = req_a[gnt_idx*WIDTH +: WIDTH];
   assign b_sel = req_b[gnt_idx*WIDTH +: WIDTH];

   // Stage p0 captures the sum at grant; later stages only delay it.
   always_ff @(posedge clock) begin
      if (reset) begin
         vld_p <= '0;
      end else begin
         vld_p[0] <= grant;
         for (int i = 1; i < LAT; i++) vld_p[i] <= vld_p[i-1];
      end
   end

   always_ff @(posedge clock) begin
      y_p[0]  <= add_wrap(a_sel, b_sel);
      id_p[0] <= gnt_idx;
      for (int i = 1; i < LAT; i++) begin
         y_p[i]  <= y_p[i-1];
         id_p[i] <= id_p[i-1];
      end
   end

   // Pipeline exit into the result FIFO.
   always_ff @(posedge clock) begin
      if (push) begin
         mem_id[wr_ptr] <= id_p[LAT-1];
         mem_y[wr_ptr]  <= y_p[LAT-1];
      end
   end

   assign rsp_id = mem_id[rd_ptr];
   assign rsp_y  = mem_y[rd_ptr];

   always_ff @(posedge clock) begin
      if (reset) begin
         ptr        <= '0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
         inflight   <= '0;
      end else begin
         if (grant) ptr <= (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + IDW'(1);
         if (push) wr_ptr <= ptr_inc(wr_ptr);
         if (pop)  rd_ptr <= ptr_inc(rd_ptr);
         case ({push, pop})
            2'b10:   fifo_count <= fifo_count + CW'(1);
            2'b01:   fifo_count <= fifo_count - CW'(1);
            default: fifo_count <= fifo_count;
         endcase
         case ({grant, push})
            2'b10:   inflight <= inflight + CW'(1);
            2'b01:   inflight <= inflight - CW'(1);
            default: inflight <= inflight;
         endcase
      end
   end

   // Credit accounting must make these unreachable.
   always_ff @(posedge clock) begin
      if (!reset) begin
         assert (!(pop && fifo_count == '0));
         assert (!(push && !pop && fifo_count == CW'(DEPTH)));
      end
   end

endmodule

// File: tb/tb_dsp_add_arbiter.sv
// Directed bench for dsp_add_arbiter: reset, single op, wrap, fairness, backpressure, mid-flight reset, sparse.
module tb_dsp_add_arbiter;

   logic        clock;
   logic        reset;
   logic [3:0]  req_valid;
   logic [3:0]  req_ready;
   logic [31:0] req_a;
   logic [31:0] req_b;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [1:0]  rsp_id;
   logic [7:0]  rsp_y;

   int n_chk = 0;
   int n_err = 0;
   logic [7:0] exp_y [4];
   int hid;

   dsp_add_arbiter #(.WIDTH(8), .NREQ(4), .LAT(2), .DEPTH(4)) dut (
      .clock     (clock),
      .reset     (reset),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_id    (rsp_id),
      .rsp_y     (rsp_y)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task to_neg;
      @(negedge clock);
   endtask

   task to_next;
      @(posedge clock);
      #1;
   endtask

   function automatic logic [7:0] golden(input int id);
      logic [7:0] a;
      logic [7:0] b;
      a = req_a[id*8 +: 8];
      b = req_b[id*8 +: 8];
      return a + b;
   endfunction

   initial begin
      exp_y[0] = 8'h15; exp_y[1] = 8'h51; exp_y[2] = 8'h40; exp_y[3] = 8'h04;
      reset = 1'b1; req_valid = 4'hF; rsp_ready = 1'b1; req_a = '0; req_b = '0;

      // Reset state
      to_neg;
      check("rst_ready", req_ready, 4'h0);
      check("rst_rsp_valid", rsp_valid, 1'b0);
      to_next;
      to_neg;
      check("rst_ready2", req_ready, 4'h0);
      to_next;

      // Single op in the first cycle after reset: 0 + (-2) = FE
      reset = 1'b0; req_valid = 4'b0001; req_a = 32'h0; req_b = 32'h0000_00FE;
      to_neg;
      check("single_ready", req_ready, 4'b0001);
      to_next;
      req_valid = 4'b0000;
      to_neg; check("single_lat0", rsp_valid, 1'b0); to_next;
      to_neg; check("single_lat1", rsp_valid, 1'b0); to_next;
      to_neg;
      check("single_valid", rsp_valid, 1'b1);
      check("single_id", rsp_id, 2'd0);
      check("single_y", rsp_y, 8'hFE);
      to_next;
      to_neg; check("single_drained", rsp_valid, 1'b0); to_next;

      // Wrap cases: 7F+01 on req 1, FF+01 on req 3
      req_a = 32'hFF00_7F00; req_b = 32'h0100_0100; req_valid = 4'b1010;
      to_neg; check("wrap_ready1", req_ready, 4'b0010); to_next;
      req_valid = 4'b1000;
      to_neg; check("wrap_ready3", req_ready, 4'b1000); to_next;
      req_valid = 4'b0000;
      to_neg; check("wrap_lat", rsp_valid, 1'b0); to_next;
      to_neg;
      check("wrap_id1", rsp_id, 2'd1);
      check("wrap_y80", rsp_y, 8'h80);
      to_next;
      to_neg;
      check("wrap_id3", rsp_id, 2'd3);
      check("wrap_y00", rsp_y, 8'h00);
      to_next;
      to_neg; check("wrap_drained", rsp_valid, 1'b0); to_next;

      // Fairness: all valid, consumer always ready
      req_a = 32'hC080_4010; req_b = 32'h44C0_1105; req_valid = 4'hF;
      for (int k = 0; k < 12; k++) begin
         to_neg;
         check($sformatf("fair_ready_%0d", k), req_ready, (k < 8) ? (4'b0001 << (k % 4)) : 4'b0000);
         check($sformatf("fair_valid_%0d", k), rsp_valid, (k >= 3 && k <= 10));
         if (k >= 3 && k <= 10) begin
            check($sformatf("fair_id_%0d", k), rsp_id, (k - 3) % 4);
            check($sformatf("fair_y_%0d", k), rsp_y, exp_y[(k - 3) % 4]);
         end
         to_next;
         if (k == 7) req_valid = 4'h0;
      end

      // Backpressure: four grants fill credit, then pops re-open grants in the same cycle
      rsp_ready = 1'b0; req_valid = 4'hF;
      for (int k = 0; k < 12; k++) begin
         if (k == 7) rsp_ready = 1'b1;
         to_neg;
         check($sformatf("bp_ready_%0d", k), req_ready,
               (k < 4) ? (4'b0001 << k) : (k >= 7) ? (4'b0001 << ((k - 7) % 4)) : 4'b0000);
         check($sformatf("bp_valid_%0d", k), rsp_valid, (k >= 3));
         if (k >= 3) begin
            hid = (k <= 7) ? 0 : (k - 7) % 4;
            check($sformatf("bp_id_%0d", k), rsp_id, hid);
            check($sformatf("bp_y_%0d", k), rsp_y, exp_y[hid]);
         end
         to_next;
      end
      req_valid = 4'h0;
      repeat (6) to_next;
      to_neg;
      check("bp_drained", rsp_valid, 1'b0);
      check("bp_ptr", dut.ptr, 2'd1);
      to_next;

      // Reset with two ops in the pipe and two in the FIFO
      rsp_ready = 1'b0; req_valid = 4'hF;
      for (int k = 0; k < 4; k++) begin
         to_neg;
         check($sformatf("mr_fill_%0d", k), req_ready, 4'b0001 << ((k + 1) % 4));
         to_next;
      end
      reset = 1'b1; rsp_ready = 1'b1;
      to_neg;
      check("mr_rst_ready", req_ready, 4'h0);
      check("mr_rst_valid", rsp_valid, 1'b0);
      to_next;
      reset = 1'b0;
      to_neg;
      check("mr_ptr", dut.ptr, 2'd0);
      check("mr_valid_after", rsp_valid, 1'b0);
      check("mr_ready0", req_ready, 4'b0001);
      to_next;
      req_valid = 4'h0;
      for (int k = 0; k < 2; k++) begin
         to_neg;
         check($sformatf("mr_no_stale_%0d", k), rsp_valid, 1'b0);
         to_next;
      end
      to_neg;
      check("mr_new_valid", rsp_valid, 1'b1);
      check("mr_new_id", rsp_id, 2'd0);
      check("mr_new_y", rsp_y, 8'h15);
      to_next;
      to_neg; check("mr_drained", rsp_valid, 1'b0); to_next;

      // Sparse: only req 2, then only req 1
      req_a = 32'h009C_5500; req_b = 32'h0023_AA00; req_valid = 4'b0100;
      to_neg; check("sp_ready2", req_ready, 4'b0100); to_next;
      req_valid = 4'b0010;
      to_neg; check("sp_ready1", req_ready, 4'b0010); to_next;
      req_valid = 4'b0000;
      to_neg;
      check("sp_ptr", dut.ptr, 2'd2);
      check("sp_lat", rsp_valid, 1'b0);
      to_next;
      to_neg;
      check("sp_id2", rsp_id, 2'd2);
      check("sp_y2", rsp_y, golden(2));
      check("sp_y2_hand", rsp_y, 8'hBF);
      to_next;
      to_neg;
      check("sp_id1", rsp_id, 2'd1);
      check("sp_y1", rsp_y, golden(1));
      check("sp_y1_hand", rsp_y, 8'hFF);
      to_next;
      to_neg; check("sp_drained", rsp_valid, 1'b0); to_next;

      $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
      $finish;
   end

endmodule
